ps2_keypad_decoder: RTL and testbench
=====================================

Name: ps2_keypad_decoder

Overview:
- Converts the raw PS/2 byte stream from the PS2 controller into key events for the calculator front end.
- Handles E0-prefixed extended codes, F0 break codes, stale prefixes and auto-repeat.
- Buffers press/release events in a FIFO with a valid/ready pop port, and holds the last released key for the display/LED path.
- Sits between the PS2 controller (received_data/received_data_en) and the interface logic.

Parameters:
- CODE_W, 5: key index width; must be >=5; upper bits zero-filled.
- FIFO_DEPTH, 8: event FIFO entries; power of two, >=2.
- TIMEOUT_CYCLES, 50000: clk cycles a prefix state waits for the next byte before abandoning it.
- REPORT_MAKE, 1: 1 = push both make and break events; 0 = push break events only.

Ports:
- clk  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from PS2 controller, clk-synchronous.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pop; a pop occurs when evt_valid && evt_ready.
- evt_code  out  CODE_W  key index of the FIFO head.
- evt_release  out  1  1 = head is a break event, 0 = make event.
- last_key  out  CODE_W  index of the most recent break event.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clear  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE, FIFO empty, evt_valid=0.
  - evt_code=0, evt_release=0, overflow=0.
  - last_key = all ones (NO_KEY).
  - Timeout counter = 0, held-key register = NO_KEY.
- Key map (index <- code):
  - 70->0, 69->1, 72->2, 7A->3, 6B->4, 73->5, 74->6, 6C->7, 75->8, 7D->9
  - 79->10(+), 7B->11(-), 7C->12(*), 71->15(.), 66->16(backspace), 76->17(esc)
  - E0 5A->13(enter/=), E0 4A->14(/)
  - Any other code (including unmapped E0 codes) is consumed with no event.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions on rx_valid only:
  - IDLE: E0->EXT; F0->BRK; mapped code->make event, stay IDLE.
  - EXT: F0->EXT_BRK; E0->EXT; other->extended make lookup, ->IDLE.
  - BRK: F0->BRK; E0->EXT_BRK; other->break lookup, ->IDLE.
  - EXT_BRK: F0->EXT_BRK; other->extended break lookup, ->IDLE.
- Timeout:
  - In any non-IDLE state the counter increments each cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, go to IDLE with no event.
  - Counter clears on rx_valid and in IDLE.
- Event generation:
  - Decoded event pushed in the cycle after the rx_valid that completes it; evt_valid rises one cycle later (FIFO latency 1).
  - Break events update last_key in the same cycle as the push, even if the push is dropped.
  - REPORT_MAKE=0: make events are not pushed.
- FIFO:
  - Registered head outputs; evt_code/evt_release are stable while evt_valid && !evt_ready.
  - Push while full: event dropped, overflow<=1.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pop while empty: ignored.
  - ovf_clear and an overflow event in the same cycle: overflow stays 1.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter distinguishes full from empty.
- Reset mid-sequence: discards any partial prefix and all FIFO contents.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - The held-key register records the index of the last make event.
  - A repeated make of the same index while held is suppressed (auto-repeat filter).
  - A break of that index clears the held-key register to NO_KEY.
  - A make of a different index replaces it.
- Undefined: every make is pushed (subject to REPORT_MAKE); no held-key register is present.

Test Plan:
- Reset low, then high; send 70, F0 70 (REPORT_MAKE=1) -> events {0,make} then {0,release}; last_key=0; evt_ready held 0 keeps the head stable.
- Send E0 5A, E0 F0 5A, E0 4A -> events {13,make}, {13,release}, {14,make}; send 1C, F0 1C -> no events.
- Send F0, then idle TIMEOUT_CYCLES cycles, then 69 -> single {1,make}; no break event.
- FIFO_DEPTH=8, evt_ready=0, send 9 makes (0..8) -> 8 entries, overflow=1; pop all returns 0..7 in order; ovf_clear -> overflow=0.
- With TYPEMATIC_FILTER_EN: 74 74 74 F0 74 74 -> {6,make}, {6,release}, {6,make}; without the macro -> four makes and one break.
- Assert Reset mid E0 F0 sequence with 3 queued events -> evt_valid=0, last_key=all ones; next 7D -> {9,make}.

Source files
------------

// File: rtl/ps2_keypad_decoder.sv
// PS/2 scan-code stream to keypad make/break events, buffered in a valid/ready pop FIFO.
// Optional macro TYPEMATIC_FILTER_EN suppresses auto-repeated makes of the currently held key.
module ps2_keypad_decoder #(
  parameter int unsigned CODE_W         = 5,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned REPORT_MAKE    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CODE_W-1:0] evt_code_o,
  output logic              evt_release_o,
  output logic [CODE_W-1:0] last_key_o,
  output logic              overflow_o,
  input  logic              ovf_clear_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned ENT_W = CODE_W + 1;
  localparam logic [CODE_W-1:0] NO_KEY = '1;
  localparam logic [CNT_W-1:0]  FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

  // {hit, index}; plain codes and E0-prefixed codes live in separate tables
  function automatic logic [5:0] map_code(input logic ext, input logic [7:0] b);
    logic [5:0] r;
    r = '0;
    if (ext) begin
      case (b)
        8'h5A:   r = {1'b1, 5'd13};
        8'h4A:   r = {1'b1, 5'd14};
        default: r = '0;
      endcase
    end else begin
      case (b)
        8'h70:   r = {1'b1, 5'd0};
        8'h69:   r = {1'b1, 5'd1};
        8'h72:   r = {1'b1, 5'd2};
        8'h7A:   r = {1'b1, 5'd3};
        8'h6B:   r = {1'b1, 5'd4};
        8'h73:   r = {1'b1, 5'd5};
        8'h74:   r = {1'b1, 5'd6};
        8'h6C:   r = {1'b1, 5'd7};
        8'h75:   r = {1'b1, 5'd8};
        8'h7D:   r = {1'b1, 5'd9};
        8'h79:   r = {1'b1, 5'd10};
        8'h7B:   r = {1'b1, 5'd11};
        8'h7C:   r = {1'b1, 5'd12};
        8'h71:   r = {1'b1, 5'd15};
        8'h66:   r = {1'b1, 5'd16};
        8'h76:   r = {1'b1, 5'd17};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  state_e             state_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               push_q;
  logic [CODE_W-1:0]  push_code_q;
  logic               push_rel_q;
`ifdef TYPEMATIC_FILTER_EN
  logic [CODE_W-1:0]  held_q;
`endif

  logic               ext_c, brk_c, hit_c;
  logic [4:0]         idx_c;
  logic [CODE_W-1:0]  key_c;

  always_comb begin
    ext_c = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    brk_c = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    {hit_c, idx_c} = map_code(ext_c, rx_data_i);
    key_c = CODE_W'(idx_c);
  end

  // Prefix FSM with stale-prefix timeout; completed codes become a one-cycle push request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
      push_rel_q  <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      held_q      <= NO_KEY;
`endif
    end else begin
      push_q <= 1'b0;
      if (rx_valid_i) begin
        tmo_q <= '0;
        if (rx_data_i == 8'hF0) begin
          case (state_q)
            S_IDLE:  state_q <= S_BRK;
            S_EXT:   state_q <= S_EXT_BRK;
            default: state_q <= state_q;
          endcase
        end else if ((rx_data_i == 8'hE0) && (state_q != S_EXT_BRK)) begin
          state_q <= (state_q == S_BRK) ? S_EXT_BRK : S_EXT;
        end else begin
          state_q <= S_IDLE;
          if (hit_c) begin
            push_code_q <= key_c;
            push_rel_q  <= brk_c;
            if (brk_c) begin
              push_q <= 1'b1;
`ifdef TYPEMATIC_FILTER_EN
              if (held_q == key_c) held_q <= NO_KEY;
`endif
            end else begin
`ifdef TYPEMATIC_FILTER_EN
              if (held_q != key_c) push_q <= (REPORT_MAKE != 0);
              held_q <= key_c;
`else
              push_q <= (REPORT_MAKE != 0);
`endif
            end
          end
        end
      end else if (state_q == S_IDLE) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LAST) begin
        state_q <= S_IDLE;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENT_W-1:0]   head_d;
  logic               pop_c, wr_c, ovf_c;

  // A full FIFO still accepts a push when the head is popped in the same cycle
  always_comb begin
    pop_c    = evt_valid_o && evt_ready_i;
    wr_c     = push_q && ((cnt_q != FULL) || pop_c);
    ovf_c    = push_q && !wr_c;
    rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_c && !pop_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!wr_c && pop_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    head_d = (wr_c && (wr_ptr_q == rd_ptr_d)) ? {push_rel_q, push_code_q} : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (wr_c) mem_q[wr_ptr_q] <= {push_rel_q, push_code_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      evt_valid_o   <= 1'b0;
      evt_code_o    <= '0;
      evt_release_o <= 1'b0;
      last_key_o    <= NO_KEY;
      overflow_o    <= 1'b0;
    end else begin
      if (wr_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      evt_valid_o   <= (cnt_d != '0);
      evt_code_o    <= head_d[CODE_W-1:0];
      evt_release_o <= head_d[CODE_W];
      if (push_q && push_rel_q) last_key_o <= push_code_q;
      if (ovf_c) begin
        overflow_o <= 1'b1;
      end else if (ovf_clear_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Self-checking bench for ps2_keypad_decoder: vector table plus hand sequences, scoreboard queue.
module tb_ps2_keypad_decoder;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TMO    = 64;

  typedef struct packed { logic [4:0] code; logic rel; } ev_t;
  typedef struct {
    int              n;
    logic [3:0][7:0] b;
    logic            ev;
    logic [4:0]      code;
    logic            rel;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              evt_valid;
  logic              evt_ready = 1'b0;
  logic [CODE_W-1:0] evt_code;
  logic              evt_release;
  logic [CODE_W-1:0] last_key;
  logic              overflow;
  logic              ovf_clear = 1'b0;

  always #5 clk = ~clk;

  ps2_keypad_decoder #(
    .CODE_W(CODE_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .REPORT_MAKE(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_code_o(evt_code),
    .evt_release_o(evt_release), .last_key_o(last_key), .overflow_o(overflow),
    .ovf_clear_i(ovf_clear)
  );

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_last = 5'h1F;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic expect_ev(input logic [4:0] c, input logic r);
    ev_t e;
    e.code = c;
    e.rel  = r;
    exp_q.push_back(e);
  endtask

  // Drive inputs for the next edge; a head that will be popped on that edge is checked now
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    ev_t e;
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    evt_ready = r;
    ovf_clear = c;
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event got code %0d rel %0b want none", evt_code, evt_release);
      end else begin
        e = exp_q.pop_front();
        chk("evt_code", 32'(evt_code), 32'(e.code));
        chk("evt_release", 32'(evt_release), 32'(e.rel));
      end
    end
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(1'b0, 8'h00, r, 1'b0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0) && (budget < 64)) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    idle(6, 1'b1);
    chk("fifo_empty_after_drain", 32'(evt_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    evt_ready = 1'b0;
    ovf_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    exp_q.delete();
    exp_last = 5'h1F;
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic ev, input logic [4:0] code, input logic rel);
    vec_t v;
    v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.ev = ev; v.code = code; v.rel = rel;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    logic [7:0] fill[8];
    fill = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C};

    vecs.push_back(mk(1, 8'h69, 0, 0, 0, 1, 5'd1, 0));
    vecs.push_back(mk(1, 8'h72, 0, 0, 0, 1, 5'd2, 0));
    vecs.push_back(mk(1, 8'h7A, 0, 0, 0, 1, 5'd3, 0));
    vecs.push_back(mk(1, 8'h6B, 0, 0, 0, 1, 5'd4, 0));
    vecs.push_back(mk(1, 8'h73, 0, 0, 0, 1, 5'd5, 0));
    vecs.push_back(mk(1, 8'h74, 0, 0, 0, 1, 5'd6, 0));
    vecs.push_back(mk(1, 8'h6C, 0, 0, 0, 1, 5'd7, 0));
    vecs.push_back(mk(1, 8'h75, 0, 0, 0, 1, 5'd8, 0));
    vecs.push_back(mk(1, 8'h7D, 0, 0, 0, 1, 5'd9, 0));
    vecs.push_back(mk(1, 8'h79, 0, 0, 0, 1, 5'd10, 0));
    vecs.push_back(mk(1, 8'h7B, 0, 0, 0, 1, 5'd11, 0));
    vecs.push_back(mk(1, 8'h7C, 0, 0, 0, 1, 5'd12, 0));
    vecs.push_back(mk(1, 8'h71, 0, 0, 0, 1, 5'd15, 0));
    vecs.push_back(mk(1, 8'h66, 0, 0, 0, 1, 5'd16, 0));
    vecs.push_back(mk(1, 8'h76, 0, 0, 0, 1, 5'd17, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h5A, 0, 0, 1, 5'd13, 0));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h5A, 0, 1, 5'd13, 1));
    vecs.push_back(mk(2, 8'hE0, 8'h4A, 0, 0, 1, 5'd14, 0));
    vecs.push_back(mk(1, 8'h1C, 0, 0, 0, 0, 5'd0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h1C, 0, 0, 0, 5'd0, 0));
    vecs.push_back(mk(2, 8'hE0, 8'h70, 0, 0, 0, 5'd0, 0));
    vecs.push_back(mk(3, 8'hF0, 8'hE0, 8'h4A, 0, 1, 5'd14, 1));
    vecs.push_back(mk(3, 8'hE0, 8'hE0, 8'h5A, 0, 1, 5'd13, 0));
    vecs.push_back(mk(3, 8'hF0, 8'hF0, 8'h66, 0, 1, 5'd16, 1));
    vecs.push_back(mk(4, 8'hE0, 8'hF0, 8'hF0, 8'h4A, 1, 5'd14, 1));
    vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'hE0, 0, 0, 5'd0, 0));
    vecs.push_back(mk(1, 8'h70, 0, 0, 0, 1, 5'd0, 0));
    vecs.push_back(mk(2, 8'hF0, 8'h76, 0, 0, 1, 5'd17, 1));

    do_reset();
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_code", 32'(evt_code), 32'd0);
    chk("rst_evt_release", 32'(evt_release), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_last_key", 32'(last_key), 32'h1F);

    // first event latency and head stability while not ready
    step(1'b1, 8'h70, 1'b0, 1'b0);
    expect_ev(5'd0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("latency_early", 32'(evt_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("latency_valid", 32'(evt_valid), 32'd1);
    chk("head_code", 32'(evt_code), 32'd0);
    chk("head_release", 32'(evt_release), 32'd0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h70, 1'b0, 1'b0);
    expect_ev(5'd0, 1'b1);
    exp_last = 5'd0;
    idle(4, 1'b0);
    chk("head_stable_code", 32'(evt_code), 32'd0);
    chk("head_stable_release", 32'(evt_release), 32'd0);
    chk("last_key_after_break", 32'(last_key), 32'(exp_last));
    drain();

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) step(1'b1, vecs[i].b[k], 1'b1, 1'b0);
      if (vecs[i].ev) begin
        expect_ev(vecs[i].code, vecs[i].rel);
        if (vecs[i].rel) exp_last = vecs[i].code;
      end
      idle(3, 1'b1);
      chk("vec_last_key", 32'(last_key), 32'(exp_last));
    end
    drain();

    // stale F0: abandoned after exactly TMO idle cycles, still live one cycle earlier
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    idle(TMO, 1'b1);
    step(1'b1, 8'h69, 1'b1, 1'b0);
    expect_ev(5'd1, 1'b0);
    idle(3, 1'b1);
    chk("timeout_last_key", 32'(last_key), 32'(exp_last));
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    idle(TMO - 1, 1'b1);
    step(1'b1, 8'h69, 1'b1, 1'b0);
    expect_ev(5'd1, 1'b1);
    exp_last = 5'd1;
    idle(3, 1'b1);
    chk("pre_timeout_last_key", 32'(last_key), 32'(exp_last));
    drain();

    // overflow: ninth push dropped, sticky flag, clear
    for (int i = 0; i < 8; i++) begin
      step(1'b1, fill[i], 1'b0, 1'b0);
      expect_ev(5'(i), 1'b0);
    end
    step(1'b1, 8'h75, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("full_valid", 32'(evt_valid), 32'd1);
    chk("full_head", 32'(evt_code), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("overflow_cleared", 32'(overflow), 32'd0);
    drain();

    // push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) begin
      step(1'b1, fill[i], 1'b0, 1'b0);
      expect_ev(5'(i), 1'b0);
    end
    idle(3, 1'b0);
    step(1'b1, 8'h75, 1'b0, 1'b0);
    expect_ev(5'd8, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("push_pop_full_no_ovf", 32'(overflow), 32'd0);
    chk("push_pop_full_valid", 32'(evt_valid), 32'd1);
    // clear coinciding with a dropped push keeps the flag
    step(1'b1, 8'h7D, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_clear_vs_drop", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("overflow_cleared2", 32'(overflow), 32'd0);
    drain();

    // auto-repeat stream
`ifdef TYPEMATIC_FILTER_EN
    expect_ev(5'd6, 1'b0);
    expect_ev(5'd6, 1'b1);
    expect_ev(5'd6, 1'b0);
`else
    expect_ev(5'd6, 1'b0);
    expect_ev(5'd6, 1'b0);
    expect_ev(5'd6, 1'b0);
    expect_ev(5'd6, 1'b1);
    expect_ev(5'd6, 1'b0);
`endif
    step(1'b1, 8'h74, 1'b1, 1'b0);
    step(1'b1, 8'h74, 1'b1, 1'b0);
    step(1'b1, 8'h74, 1'b1, 1'b0);
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    step(1'b1, 8'h74, 1'b1, 1'b0);
    step(1'b1, 8'h74, 1'b1, 1'b0);
    exp_last = 5'd6;
    idle(3, 1'b1);
    chk("repeat_last_key", 32'(last_key), 32'(exp_last));
    drain();

    // reset in the middle of E0 F0 with queued events
    step(1'b1, 8'h70, 1'b0, 1'b0);
    step(1'b1, 8'h69, 1'b0, 1'b0);
    step(1'b1, 8'h72, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("queued_before_reset", 32'(evt_valid), 32'd1);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    do_reset();
    chk("midrst_evt_valid", 32'(evt_valid), 32'd0);
    chk("midrst_last_key", 32'(last_key), 32'h1F);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    step(1'b1, 8'h7D, 1'b1, 1'b0);
    expect_ev(5'd9, 1'b0);
    idle(3, 1'b1);
    chk("midrst_last_key_after", 32'(last_key), 32'h1F);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
